// File: rtl/rot_enc_pkg.sv
// rot_enc_pkg: decode-mode constants and the Gray-code step decoder shared by
// every quadrature channel.
package rot_enc_pkg;
  localparam int MODE_X1 = 0;
  localparam int MODE_X2 = 1;
  localparam int MODE_X4 = 2;
  // Returns {count, up, illegal}; A is bit 1, B is bit 0, A leading B means up.
  function automatic logic [2:0] gray_decode(input logic [1:0] prev, input logic [1:0] cur, input int mode);
    logic [1:0] d;
    logic ill, fwd, cnt;
    d = prev ^ cur;
    ill = &d;
    fwd = {prev, cur} inside {4'b0010, 4'b1011, 4'b1101, 4'b0100};
    cnt = mode == MODE_X4 ? (|d && !ill) :
          mode == MODE_X2 ? (d == 2'b10) :
          ({prev, cur} == 4'b0010 || {prev, cur} == 4'b1000);
    return {cnt, fwd, ill};
  endfunction
endpackage

// File: rtl/rot_encoder_channel.sv
// rot_encoder_channel: one quadrature input chain - synchroniser, glitch filter,
// Gray decode and a bounded position counter with wrap/saturate and load.
module rot_encoder_channel
  import rot_enc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MIN    = 0,
  parameter int MAX    = 255,
  parameter int STEP   = 1,
  parameter int WRAP   = 1,
  parameter int MODE   = 1,
  parameter int FILTER = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             step,
  output logic             dir,
  output logic             err
);
  localparam int W1 = WIDTH + 1;
  localparam logic [WIDTH:0] LO = W1'(MIN);
  localparam logic [WIDTH:0] HI = W1'(MAX);
  localparam logic [WIDTH:0] ST = W1'(STEP);
  localparam logic [WIDTH:0] ONE = W1'(1);
  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  logic [1:0] s1_q, s2_q, vld_q, filt_q, filt_d, prev_q;
  logic [3:0] cnt_q, cnt_d;
  logic fv_q, primed_q, go;
  logic [2:0] dec;
  logic [WIDTH:0] ext, up_sum, up_res, dn_res;
  logic [WIDTH-1:0] val_q, val_d, cnt_res, ld_cl;
  logic step_q, step_d, dir_q, dir_d, err_q, err_d;
  // Until the synchroniser has real pin data, the filter copies it straight in,
  // so an idle level other than 00 never looks like a transition.
  always_comb begin
    filt_d = filt_q;
    cnt_d = cnt_q;
    if (!fv_q || FILTER == 0) filt_d = s2_q;
    else if (s2_q == filt_q) cnt_d = '0;
    else if (cnt_q == 4'(FILTER)) begin
      filt_d = s2_q;
      cnt_d = '0;
    end else cnt_d = cnt_q + 4'd1;
  end
  always_comb begin
    dec = gray_decode(prev_q, filt_q, MODE);
    go = primed_q && dec[2];
    ext = {1'b0, val_q};
    up_sum = ext + ST;
    up_res = up_sum > HI ? (WRAP != 0 ? LO + up_sum - HI - ONE : HI) : up_sum;
    dn_res = ext >= LO + ST ? ext - ST : (WRAP != 0 ? HI - (LO + ST - ext - ONE) : LO);
    cnt_res = WIDTH'(dec[1] ? up_res : dn_res);
    ld_cl = load_value < MIN_W ? MIN_W : load_value > MAX_W ? MAX_W : load_value;
    val_d = load ? ld_cl : go ? cnt_res : val_q;
    step_d = !load && go && cnt_res != val_q;
    dir_d = step_d ? dec[1] : dir_q;
    err_d = primed_q && dec[0];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
      vld_q <= '0;
      filt_q <= '0;
      cnt_q <= '0;
      fv_q <= 1'b0;
      prev_q <= '0;
      primed_q <= 1'b0;
      val_q <= MIN_W;
      step_q <= 1'b0;
      dir_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      s1_q <= {a, b};
      s2_q <= s1_q;
      vld_q <= {vld_q[0], 1'b1};
      filt_q <= filt_d;
      cnt_q <= cnt_d;
      fv_q <= fv_q | vld_q[1];
      if (fv_q) prev_q <= filt_q;
      primed_q <= primed_q | fv_q;
      val_q <= val_d;
      step_q <= step_d;
      dir_q <= dir_d;
      err_q <= err_d;
    end
  end
  assign value = val_q;
  assign step = step_q;
  assign dir = dir_q;
  assign err = err_q;
endmodule

// File: rtl/rot_encoder_multi.sv
// rot_encoder_multi: N independent quadrature decoder channels with packed
// position outputs, one channel per player paddle.
module rot_encoder_multi
  import rot_enc_pkg::*;
#(
  parameter int N      = 2,
  parameter int WIDTH  = 8,
  parameter int MIN    = 0,
  parameter int MAX    = 255,
  parameter int STEP   = 1,
  parameter int WRAP   = 1,
  parameter int MODE   = MODE_X2,
  parameter int FILTER = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       a,
  input  logic [N-1:0]       b,
  input  logic [N-1:0]       load,
  input  logic [WIDTH-1:0]   load_value,
  output logic [N*WIDTH-1:0] value,
  output logic [N-1:0]       step,
  output logic [N-1:0]       dir,
  output logic [N-1:0]       err
);
  for (genvar i = 0; i < N; i++) begin : g_ch
    rot_encoder_channel #(
      .WIDTH(WIDTH), .MIN(MIN), .MAX(MAX), .STEP(STEP),
      .WRAP(WRAP), .MODE(MODE), .FILTER(FILTER)
    ) u_ch (
      .clk(clk), .reset(reset), .a(a[i]), .b(b[i]), .load(load[i]),
      .load_value(load_value), .value(value[i*WIDTH +: WIDTH]),
      .step(step[i]), .dir(dir[i]), .err(err[i])
    );
  end
endmodule
